// File: rtl/mac2_ctrl.sv
// Sequencer for a two-accumulator MAC kernel: clears it, runs the loop until the
// kernel's branch says exit (or a watchdog fires), drains the pipeline, then captures the results.
module mac2_ctrl #(
   parameter int WIDTH        = 32,
   parameter int DRAIN_CYCLES = 3,
   parameter int MAX_CYCLES   = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] bound,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic             kern_en,
   output logic             kern_rst,
   output logic [WIDTH-1:0] kern_bound,
   input  logic             kern_br,
   input  logic [WIDTH-1:0] kern_acc0,
   input  logic [WIDTH-1:0] kern_acc1,
   output logic [WIDTH-1:0] res0,
   output logic [WIDTH-1:0] res1,
   output logic [WIDTH-1:0] cycles
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0]    DRN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
   localparam logic [WIDTH-1:0] WD_LAST  = WIDTH'(MAX_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

   state_t          state, nxt;
   logic            clr_cnt;
   logic [DW-1:0]   drn_cnt;
   logic            wd_hit;
   logic            kern_rst_q;

   // The kernel must see reset for as long as the controller does, not a cycle late.
   assign kern_rst = kern_rst_q | rst;

   always_comb begin
      nxt    = state;
      wd_hit = 1'b0;
      case (state)
         IDLE:  if (start) nxt = CLEAR;
         CLEAR: if (clr_cnt) nxt = RUN;
         RUN: begin
            // cycles==0 marks the first RUN cycle, where kern_br is not yet meaningful
            if (cycles != '0 && !kern_br) begin
               if (DRAIN_CYCLES == 0) nxt = DONE;
               else                   nxt = DRAIN;
            end else if (cycles == WD_LAST) begin
               nxt    = DONE;
               wd_hit = 1'b1;
            end
         end
         DRAIN: if (drn_cnt == DRN_LAST) nxt = DONE;
         DONE:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         kern_en    <= 1'b0;
         kern_rst_q <= 1'b0;
         kern_bound <= '0;
         res0       <= '0;
         res1       <= '0;
         cycles     <= '0;
         clr_cnt    <= 1'b0;
         drn_cnt    <= '0;
      end else begin
         state      <= nxt;
         busy       <= (nxt == CLEAR) || (nxt == RUN) || (nxt == DRAIN);
         done       <= (nxt == DONE);
         kern_en    <= (nxt == RUN) || (nxt == DRAIN);
         kern_rst_q <= (nxt == CLEAR);
         clr_cnt    <= (state == CLEAR) ? ~clr_cnt : 1'b0;
         drn_cnt    <= (state == DRAIN) ? drn_cnt + DW'(1) : '0;
         if (state == IDLE && start) begin
            kern_bound <= bound;
            cycles     <= '0;
            timeout    <= 1'b0;
         end
         if ((state == RUN || state == DRAIN) && cycles != '1)
            cycles <= cycles + WIDTH'(1);
         if (wd_hit)
            timeout <= 1'b1;
         if (nxt == DONE) begin
            res0 <= kern_acc0;
            res1 <= kern_acc1;
         end
      end
   end

endmodule
